vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller. It generates horizontal and vertical sync, the active-video flag, and pixel coordinates for any resolution and sync polarity, with a pixel clock-enable derived from the system clock. Coordinates are issued a configurable number of pixels ahead of the sync and active outputs, so a pipelined colour mapper or sprite fetch path lines up with them exactly. It sits between the system clock and the colour mapper, and drives the VGA_HS/VGA_VS pins.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_delay_line.sv | 49 ++++
 rtl/vga_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Video mode descriptor, stock mode constants and total helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_mode_t;

  localparam vga_mode_t VGA_640X480_60 = '{
    16'd640, 16'd16, 16'd96, 16'd48,
    16'd480, 16'd10, 16'd2,  16'd33,
    1'b0, 1'b0
  };

  localparam vga_mode_t SVGA_800X600_60 = '{
    16'd800, 16'd40, 16'd128, 16'd88,
    16'd600, 16'd1,  16'd4,   16'd23,
    1'b1, 1'b1
  };

  function automatic int h_total(input vga_mode_t m);
    return int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
  endfunction

  function automatic int v_total(input vga_mode_t m);
    return int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module   : vga_delay_line
// Purpose  : Clock-enable gated shift register; DEPTH = 0 is a wire.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_w;
      assign unused_w = ^{clk_i, reset_i, ce_i};
      assign q_o      = d_i;
    end else begin : g_shift
      logic [W-1:0] stage_q [DEPTH];

      // Stages reset to all-zero, which is the "flag not asserted" state.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else if (ce_i) begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA sync/active/coordinate generator with a
//            configurable coordinate lead over the sync and active outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = int'(VGA_640X480_60.h_active),
  parameter int   H_FP     = int'(VGA_640X480_60.h_fp),
  parameter int   H_SYNC   = int'(VGA_640X480_60.h_sync),
  parameter int   H_BP     = int'(VGA_640X480_60.h_bp),
  parameter int   V_ACTIVE = int'(VGA_640X480_60.v_active),
  parameter int   V_FP     = int'(VGA_640X480_60.v_fp),
  parameter int   V_SYNC   = int'(VGA_640X480_60.v_sync),
  parameter int   V_BP     = int'(VGA_640X480_60.v_bp),
  parameter logic HS_POL   = VGA_640X480_60.hs_pol,
  parameter logic VS_POL   = VGA_640X480_60.vs_pol,
  parameter int   LEAD     = 2,
  parameter int   XW       = 10,
  parameter int   YW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_ce,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic [XW-1:0] draw_x,
  output logic [YW-1:0] draw_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  localparam vga_mode_t MODE = '{
    16'(H_ACTIVE), 16'(H_FP), 16'(H_SYNC), 16'(H_BP),
    16'(V_ACTIVE), 16'(V_FP), 16'(V_SYNC), 16'(V_BP),
    HS_POL, VS_POL
  };
  localparam int H_TOTAL = h_total(MODE);
  localparam int V_TOTAL = v_total(MODE);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if ((2 ** XW) < H_TOTAL || (2 ** YW) < V_TOTAL) begin : g_bad_width
      $error("vga_timing_gen: XW/YW too narrow for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1 || LEAD < 0 || LEAD > 7) begin : g_bad_param
      $error("vga_timing_gen: CLK_DIV must be >= 1 and LEAD within 0..7");
    end
  endgenerate

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          active_q, active_d;

  logic          w_pix_ce;
  logic          w_x_end;
  logic          w_y_end;
  logic          w_line_wrap;
  logic          w_frame_wrap;
  logic [2:0]    w_raw;
  logic [2:0]    w_del;

  // Reset also masks the tick so CLK_DIV = 1 does not pulse during reset.
  assign w_pix_ce     = enable & ~reset & (int'(div_q) == CLK_DIV - 1);
  assign w_x_end      = (int'(x_q) == H_TOTAL - 1);
  assign w_y_end      = (int'(y_q) == V_TOTAL - 1);
  assign w_line_wrap  = w_pix_ce & w_x_end;
  assign w_frame_wrap = w_line_wrap & w_y_end;

  // Raw flags, ordered {hsync, vsync, active}, taken from the fetch position.
  assign w_raw[2] = (int'(x_q) >= H_ACTIVE + H_FP) &&
                    (int'(x_q) <  H_ACTIVE + H_FP + H_SYNC);
  assign w_raw[1] = (int'(y_q) >= V_ACTIVE + V_FP) &&
                    (int'(y_q) <  V_ACTIVE + V_FP + V_SYNC);
  assign w_raw[0] = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);

  vga_delay_line #(
    .DEPTH (LEAD),
    .W     (3)
  ) u_delay (
    .clk_i   (clk),
    .reset_i (reset),
    .ce_i    (w_pix_ce),
    .d_i     (w_raw),
    .q_o     (w_del)
  );

  always_comb begin
    div_d         = div_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    active_d      = active_q;
    line_start_d  = w_line_wrap;
    frame_start_d = w_frame_wrap;

    if (enable) begin
      div_d    = (int'(div_q) == CLK_DIV - 1) ? '0 : div_q + DW'(1);
      hs_d     = w_del[2] ^ ~HS_POL;
      vs_d     = w_del[1] ^ ~VS_POL;
      active_d = w_del[0];
    end

    if (w_pix_ce) begin
      if (w_x_end) begin
        x_d = '0;
        y_d = w_y_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    if (w_frame_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      active_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
    end
  end

  assign pix_ce      = w_pix_ce;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign active      = active_q;
  assign draw_x      = x_q;
  assign draw_y      = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for three vga_timing_gen configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    logic        pix_ce;
    logic        hs;
    logic        vs;
    logic        active;
    logic        ls;
    logic        fs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
  } exp_t;

  localparam vga_mode_t M_B = '{16'd8, 16'd1, 16'd2, 16'd1,
                                16'd4, 16'd1, 16'd1, 16'd1, 1'b1, 1'b0};
  localparam vga_mode_t M_C = '{16'd10, 16'd2, 16'd3, 16'd1,
                                16'd5, 16'd1, 16'd2, 16'd1, 1'b0, 1'b1};
  localparam int DV[3] = '{2, 1, 2};
  localparam int LD[3] = '{2, 0, 5};
  localparam int NCYC  = 4700;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  pce, hs, vs, act, ls, fs;
  logic [9:0]  dx [3];
  logic [9:0]  dy [3];
  logic [15:0] fc [3];

  int          n_cmp;
  int          n_bad;
  exp_t        sb [$];
  int          k [3];
  logic [15:0] off [3];

  int   en_clks, last_fall, t656, falls, last_fs_b;
  bit   seen656;
  logic prev_hs;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst), .enable(en), .pix_ce(pce[0]), .hs(hs[0]),
    .vs(vs[0]), .active(act[0]), .draw_x(dx[0]), .draw_y(dy[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .LEAD(0), .XW(10), .YW(10)
  ) dut_b (
    .clk(clk), .reset(rst), .enable(en), .pix_ce(pce[1]), .hs(hs[1]),
    .vs(vs[1]), .active(act[1]), .draw_x(dx[1]), .draw_y(dy[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1])
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .LEAD(5), .XW(10), .YW(10)
  ) dut_c (
    .clk(clk), .reset(rst), .enable(en), .pix_ce(pce[2]), .hs(hs[2]),
    .vs(vs[2]), .active(act[2]), .draw_x(dx[2]), .draw_y(dy[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2])
  );

  function automatic vga_mode_t mode_of(input int i);
    case (i)
      0:       return VGA_640X480_60;
      1:       return M_B;
      default: return M_C;
    endcase
  endfunction

  function automatic string nm(input int i);
    case (i)
      0:       return "a";
      1:       return "b";
      default: return "c";
    endcase
  endfunction

  // Expected outputs after k enabled, non-reset edges since the last reset.
  function automatic exp_t predict(input vga_mode_t m, input int d, input int l,
                                   input int kk, input bit e_en, input bit e_rst,
                                   input logic [15:0] fc_off);
    exp_t e;
    int ha, hf, hsy, va, vf, vsy, ht, vt, ft, t, p, px, py;
    ha  = int'(m.h_active); hf = int'(m.h_fp); hsy = int'(m.h_sync);
    va  = int'(m.v_active); vf = int'(m.v_fp); vsy = int'(m.v_sync);
    ht  = ha + hf + hsy + int'(m.h_bp);
    vt  = va + vf + vsy + int'(m.v_bp);
    ft  = ht * vt;
    e   = '0;
    t   = kk / d;
    e.x = 10'(t % ht);
    e.y = 10'((t / ht) % vt);
    e.fc = fc_off + 16'(t / ft);
    e.pix_ce = e_en && !e_rst && ((kk % d) == d - 1);
    if (e_en && !e_rst && kk > 0 && (kk % d) == 0) begin
      e.ls = (t % ht) == 0;
      e.fs = (t % ft) == 0;
    end
    e.hs = ~m.hs_pol;
    e.vs = ~m.vs_pol;
    p = (e_rst || kk == 0) ? -1 : (kk - 1) / d - l;
    if (p >= 0) begin
      px = p % ht;
      py = (p / ht) % vt;
      if (px >= ha + hf && px < ha + hf + hsy) e.hs = m.hs_pol;
      if (py >= va + vf && py < va + vf + vsy) e.vs = m.vs_pol;
      e.active = (px < ha) && (py < va);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic push_all();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        k[i]   = 0;
        off[i] = 16'h0;
      end else if (en) begin
        k[i]++;
      end
      sb.push_back(predict(mode_of(i), DV[i], LD[i], k[i], en, rst, off[i]));
    end
  endtask

  task automatic compare_all();
    exp_t  e;
    string p;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      p = nm(i);
      chk({p, ".pix_ce"},      32'(pce[i]), 32'(e.pix_ce));
      chk({p, ".hs"},          32'(hs[i]),  32'(e.hs));
      chk({p, ".vs"},          32'(vs[i]),  32'(e.vs));
      chk({p, ".active"},      32'(act[i]), 32'(e.active));
      chk({p, ".draw_x"},      32'(dx[i]),  32'(e.x));
      chk({p, ".draw_y"},      32'(dy[i]),  32'(e.y));
      chk({p, ".line_start"},  32'(ls[i]),  32'(e.ls));
      chk({p, ".frame_start"}, 32'(fs[i]),  32'(e.fs));
      chk({p, ".frame_count"}, 32'(fc[i]),  32'(e.fc));
    end
  endtask

  // Interval measurements in enabled clocks, independent of the per-clock model.
  task automatic measure(input int n);
    if (en && !rst) en_clks++;
    if (!seen656 && dx[0] == 10'd656) begin
      seen656 = 1'b1;
      t656    = en_clks;
    end
    if (prev_hs && !hs[0]) begin
      if (falls == 0) chk("a.hs_lag", 32'(en_clks - t656), 32'd5);
      if (falls == 1) chk("a.hs_period", 32'(en_clks - last_fall), 32'd1600);
      falls++;
      last_fall = en_clks;
    end
    if (!prev_hs && hs[0] && falls == 1) begin
      chk("a.hs_low", 32'(en_clks - last_fall), 32'd192);
    end
    prev_hs = hs[0];
    if (fs[1]) begin
      if (last_fs_b >= 0 && n < 3900) chk("b.fs_period", 32'(en_clks - last_fs_b), 32'd84);
      last_fs_b = en_clks;
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    en_clks   = 0;
    last_fall = 0;
    t656      = 0;
    falls     = 0;
    last_fs_b = -1;
    seen656   = 1'b0;
    prev_hs   = 1'b1;
    rst       = 1'b1;
    en        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k[i]   = 0;
      off[i] = 16'h0;
    end
    push_all();

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      compare_all();
      measure(n);

      rst = (n < 2) || (n == 4000);
      en  = !(n >= 1800 && n < 1850);

      if (n == 4300) begin
        force dut_c.frame_count_q = 16'hFFFF;
        off[2] = 16'hFFFF - 16'((k[2] / DV[2]) / (h_total(M_C) * v_total(M_C)));
        #1;
        release dut_c.frame_count_q;
      end

      push_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
